// File: rtl/cond_logic.sv
// Conditional-execution stage: holds N,Z,C,V and gates decoder strobes
// by the instruction's condition field evaluated on the stored flags.
module cond_logic (
   input  logic       clk,
   input  logic       reset,
   input  logic       En,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic [1:0] FlagW,
   input  logic       PCS,
   input  logic       RegW,
   input  logic       MemW,
   input  logic       NoWrite,
   output logic       PCSrc,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       CondEx,
   output logic [3:0] Flags
);

   logic [1:0] nz_q, nz_d;
   logic [1:0] cv_q, cv_d;
   logic       n, z, c, v;
   logic       cond_res;
   logic       cond_ex;

   assign Flags = {nz_q, cv_q};
   assign {n, z} = nz_q;
   assign {c, v} = cv_q;

   always_comb begin
      cond_res = 1'b0;
      unique case (Cond)
         4'b0000: cond_res = z;
         4'b0001: cond_res = ~z;
         4'b0010: cond_res = c;
         4'b0011: cond_res = ~c;
         4'b0100: cond_res = n;
         4'b0101: cond_res = ~n;
         4'b0110: cond_res = v;
         4'b0111: cond_res = ~v;
         4'b1000: cond_res = c & ~z;
         4'b1001: cond_res = ~c | z;
         4'b1010: cond_res = (n == v);
         4'b1011: cond_res = (n != v);
         4'b1100: cond_res = ~z & (n == v);
         4'b1101: cond_res = z | (n != v);
         4'b1110: cond_res = 1'b1;
         4'b1111: cond_res = 1'b0;
         default: cond_res = 1'b0;
      endcase
   end

   assign cond_ex  = cond_res & En;
   assign CondEx   = cond_ex;
   assign PCSrc    = PCS & cond_ex;
   assign RegWrite = RegW & cond_ex & ~NoWrite;
   assign MemWrite = MemW & cond_ex;

   always_comb begin
      nz_d = nz_q;
      cv_d = cv_q;
      if (FlagW[1] & cond_ex) nz_d = ALUFlags[3:2];
      if (FlagW[0] & cond_ex) cv_d = ALUFlags[1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nz_q <= 2'b00;
         cv_q <= 2'b00;
      end else begin
         nz_q <= nz_d;
         cv_q <= cv_d;
      end
   end

endmodule

// File: tb/tb_cond_logic.sv
// Directed testbench for cond_logic.
module tb_cond_logic;

   logic       clk = 1'b0;
   logic       reset;
   logic       En;
   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       PCS, RegW, MemW, NoWrite;
   logic       PCSrc, RegWrite, MemWrite, CondEx;
   logic [3:0] Flags;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cond_logic dut (
      .clk(clk), .reset(reset), .En(En), .Cond(Cond),
      .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS),
      .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
      .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
      .CondEx(CondEx), .Flags(Flags)
   );

   task automatic idle();
      En = 1'b0; Cond = 4'b1110; ALUFlags = 4'b0000; FlagW = 2'b00;
      PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
   endtask

   task automatic load_flags(input logic [3:0] val);
      @(negedge clk);
      idle();
      En = 1'b1; FlagW = 2'b11; ALUFlags = val;
      @(posedge clk); #1;
      idle();
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b0;
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (Flags !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=0000", Flags);
      end
      En = 1'b1; Cond = 4'b0000; #1;
      checks++;
      if (CondEx !== 1'b0) begin
         failures++;
         $display("FAIL reset_eq got=%b exp=0", CondEx);
      end
      Cond = 4'b0001; #1;
      checks++;
      if (CondEx !== 1'b1) begin
         failures++;
         $display("FAIL reset_ne got=%b exp=1", CondEx);
      end
      @(negedge clk);
      reset = 1'b0;
      idle();
   endtask

   task automatic test_flag_branch();
      load_flags(4'b0000);
      @(negedge clk);
      En = 1'b1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0100;
      #1;
      checks++;
      if (Flags !== 4'b0000) begin
         failures++;
         $display("FAIL pre_edge_flags got=%b exp=0000", Flags);
      end
      @(posedge clk); #1;
      FlagW = 2'b00; ALUFlags = 4'b0000;
      checks++;
      if (Flags !== 4'b0100) begin
         failures++;
         $display("FAIL branch_flags got=%b exp=0100", Flags);
      end
      PCS = 1'b1; Cond = 4'b0000; #1;
      checks++;
      if (PCSrc !== 1'b1) begin
         failures++;
         $display("FAIL branch_eq got=%b exp=1", PCSrc);
      end
      Cond = 4'b0001; #1;
      checks++;
      if (PCSrc !== 1'b0) begin
         failures++;
         $display("FAIL branch_ne got=%b exp=0", PCSrc);
      end
      idle();
   endtask

   task automatic test_partial();
      load_flags(4'b0011);
      @(negedge clk);
      En = 1'b1; Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b1100;
      @(posedge clk); #1;
      checks++;
      if (Flags !== 4'b1111) begin
         failures++;
         $display("FAIL partial_nz got=%b exp=1111", Flags);
      end
      @(negedge clk);
      FlagW = 2'b01; ALUFlags = 4'b0000;
      @(posedge clk); #1;
      checks++;
      if (Flags !== 4'b1100) begin
         failures++;
         $display("FAIL partial_cv got=%b exp=1100", Flags);
      end
      idle();
   endtask

   task automatic test_compare();
      load_flags(4'b0000);
      @(negedge clk);
      En = 1'b1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0100;
      RegW = 1'b1; NoWrite = 1'b1;
      #1;
      checks++;
      if (RegWrite !== 1'b0 || CondEx !== 1'b1) begin
         failures++;
         $display("FAIL cmp_regw got=%b%b exp=01", RegWrite, CondEx);
      end
      @(posedge clk); #1;
      checks++;
      if (Flags !== 4'b0100) begin
         failures++;
         $display("FAIL cmp_load got=%b exp=0100", Flags);
      end
      load_flags(4'b0000);
      @(negedge clk);
      En = 1'b1; Cond = 4'b0000; FlagW = 2'b11; ALUFlags = 4'b1111;
      MemW = 1'b1;
      #1;
      checks++;
      if (MemWrite !== 1'b0 || CondEx !== 1'b0) begin
         failures++;
         $display("FAIL cmp_fail_memw got=%b%b exp=00", MemWrite, CondEx);
      end
      @(posedge clk); #1;
      checks++;
      if (Flags !== 4'b0000) begin
         failures++;
         $display("FAIL cmp_fail_hold got=%b exp=0000", Flags);
      end
      idle();
   endtask

   task automatic test_signed();
      logic [3:0] fl [9];
      logic [3:0] cd [9];
      logic       ex [9];
      fl = '{4'b1001, 4'b1001, 4'b1001, 4'b1001,
             4'b1000, 4'b1000, 4'b1000, 4'b0110, 4'b0110};
      cd = '{4'b1010, 4'b1011, 4'b1100, 4'b1101,
             4'b1010, 4'b1011, 4'b1101, 4'b1000, 4'b1001};
      ex = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 9; i++) begin
         if (i == 0 || fl[i] != fl[i-1]) load_flags(fl[i]);
         En = 1'b1; Cond = cd[i]; #1;
         checks++;
         if (CondEx !== ex[i]) begin
            failures++;
            $display("FAIL signed flags=%b cond=%b got=%b exp=%b",
                     fl[i], cd[i], CondEx, ex[i]);
         end
      end
      for (int i = 0; i < 2; i++) begin
         load_flags(i == 0 ? 4'b0000 : 4'b1111);
         En = 1'b1; Cond = 4'b1111; PCS = 1'b1; #1;
         checks++;
         if (CondEx !== 1'b0 || PCSrc !== 1'b0) begin
            failures++;
            $display("FAIL nv_%0d got=%b%b exp=00", i, CondEx, PCSrc);
         end
      end
      idle();
   endtask

   task automatic test_stall();
      load_flags(4'b0101);
      @(negedge clk);
      En = 1'b0; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1111;
      RegW = 1'b1; MemW = 1'b1; PCS = 1'b1;
      #1;
      checks++;
      if ({PCSrc, RegWrite, MemWrite, CondEx} !== 4'b0000) begin
         failures++;
         $display("FAIL stall_strobes got=%b exp=0000",
                  {PCSrc, RegWrite, MemWrite, CondEx});
      end
      @(posedge clk); #1;
      checks++;
      if (Flags !== 4'b0101) begin
         failures++;
         $display("FAIL stall_hold got=%b exp=0101", Flags);
      end
      idle();
   endtask

   task automatic test_reset_mid();
      load_flags(4'b1111);
      @(negedge clk);
      En = 1'b1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1111;
      #1 reset = 1'b1;
      #1;
      checks++;
      if (Flags !== 4'b0000) begin
         failures++;
         $display("FAIL mid_reset_flags got=%b exp=0000", Flags);
      end
      Cond = 4'b0100; #1;
      checks++;
      if (CondEx !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_mi got=%b exp=0", CondEx);
      end
      Cond = 4'b1110;
      @(posedge clk); #1;
      checks++;
      if (Flags !== 4'b0000) begin
         failures++;
         $display("FAIL reset_edge_load got=%b exp=0000", Flags);
      end
      @(negedge clk);
      reset = 1'b0;
      idle();
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_flag_branch();
      test_partial();
      test_compare();
      test_signed();
      test_stall();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
